rc4_ksa_prga_ctrl: RTL and testbench

- Sequencer that drives the 16-entry × 4-bit RC4 S-array storage block.
- Runs three phases in order: S-array initialisation, key scheduling (KSA) and keystream generation (PRGA).
- Issues read addresses and dual-port swap writes to the array, and consumes the array's registered read data.
- Delivers 4-bit keystream nibbles downstream over a valid/ready handshake.

---
 rtl/rc4_ksa_prga_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_rc4_ksa_prga_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_prga_ctrl.sv
// rc4_ksa_prga_ctrl
// -----------------
// Sequencer for a 16-entry x 4-bit RC4 S-array. After a start pulse it
// initialises the array, runs the key schedule and then generates keystream
// nibbles until halted.
//
// Timing model: every output is a register. The values listed for a state
// are loaded on the edge that enters it, so they are visible for that
// state's whole cycle. The array captures the read address on the falling
// edge, so read data is sampled on the edge that leaves the read state.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle start pulse (IDLE only); key sampled then
//   halt              synchronous abort to IDLE, highest priority
//   key               KEYLEN key nibbles, nibble 0 in bits [3:0]
//   s_rd_addr         array read address
//   s_rd_data         array read data (registered inside the array)
//   s_wr_en           array write enable (0 = array reads)
//   s_wr_addr1/2      array write addresses, ports 1 and 2
//   s_wr_data1/2      array write data, ports 1 and 2
//   ks, ks_valid      keystream nibble and its valid flag
//   ks_ready          downstream accepts ks
//   busy              high in every state except IDLE
module rc4_ksa_prga_ctrl #(
  parameter int KEYLEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [4*KEYLEN-1:0]   key,
  output logic [3:0]            s_rd_addr,
  input  logic [3:0]            s_rd_data,
  output logic                  s_wr_en,
  output logic [3:0]            s_wr_addr1,
  output logic [3:0]            s_wr_data1,
  output logic [3:0]            s_wr_addr2,
  output logic [3:0]            s_wr_data2,
  output logic [3:0]            ks,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic                  busy
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] INIT  = 4'd1;
  localparam logic [3:0] K_RI  = 4'd2;
  localparam logic [3:0] K_RJ  = 4'd3;
  localparam logic [3:0] K_SW  = 4'd4;
  localparam logic [3:0] P_RI  = 4'd5;
  localparam logic [3:0] P_RJ  = 4'd6;
  localparam logic [3:0] P_SW  = 4'd7;
  localparam logic [3:0] P_RT  = 4'd8;
  localparam logic [3:0] P_OUT = 4'd9;

  logic [3:0]          state_q, state_d;
  logic [3:0]          i_q, i_d;
  logic [3:0]          j_q, j_d;
  logic [3:0]          si_q, si_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [4*KEYLEN-1:0] key_q, key_d;
  logic [3:0]          rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [3:0]          wa1_q, wa1_d, wd1_q, wd1_d;
  logic [3:0]          wa2_q, wa2_d, wd2_q, wd2_d;
  logic [3:0]          ks_q, ks_d;
  logic                ks_valid_q, ks_valid_d;
  logic                busy_q, busy_d;
  logic [3:0]          key_nib;

  // Key nibble for the current KSA index, wrapping modulo KEYLEN.
  always_comb begin
    key_nib = key_q[4*(int'(i_q) % KEYLEN) +: 4];
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;   // writes last exactly one cycle unless re-asserted
    wa1_d      = wa1_q;
    wd1_d      = wd1_q;
    wa2_d      = wa2_q;
    wd2_d      = wd2_q;
    ks_d       = ks_q;
    ks_valid_d = ks_valid_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          state_d = INIT;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          wr_en_d = 1'b1;
          wa1_d   = 4'd0;
          wd1_d   = 4'd0;
          wa2_d   = 4'd1;
          wd2_d   = 4'd1;
        end
      end
      INIT: begin
        if (cnt_q == 3'd7) begin
          state_d   = K_RI;
          i_d       = 4'd0;
          j_d       = 4'd0;
          rd_addr_d = 4'd0;
        end else begin
          // Two entries per cycle: even address on port 1, odd on port 2.
          cnt_d   = cnt_q + 3'd1;
          wr_en_d = 1'b1;
          wa1_d   = {cnt_d, 1'b0};
          wd1_d   = {cnt_d, 1'b0};
          wa2_d   = {cnt_d, 1'b1};
          wd2_d   = {cnt_d, 1'b1};
        end
      end
      K_RI: begin
        state_d   = K_RJ;
        si_d      = s_rd_data;
        j_d       = j_q + s_rd_data + key_nib;
        rd_addr_d = j_d;
      end
      K_RJ, P_RJ: begin
        // Swap: S[i] <= S[j] on port 1, S[j] <= S[i] on port 2.
        state_d = (state_q == K_RJ) ? K_SW : P_SW;
        wr_en_d = 1'b1;
        wa1_d   = i_q;
        wd1_d   = s_rd_data;
        wa2_d   = j_q;
        wd2_d   = si_q;
      end
      K_SW: begin
        if (i_q == 4'd15) begin
          // PRGA starts from i=0, j=0 and pre-increments i on entry.
          state_d   = P_RI;
          i_d       = 4'd1;
          j_d       = 4'd0;
          rd_addr_d = 4'd1;
        end else begin
          state_d   = K_RI;
          i_d       = i_q + 4'd1;
          rd_addr_d = i_d;
        end
      end
      P_RI: begin
        state_d   = P_RJ;
        si_d      = s_rd_data;
        j_d       = j_q + s_rd_data;
        rd_addr_d = j_d;
      end
      P_SW: begin
        // The write data registers still hold sj (port 1) and si (port 2).
        state_d   = P_RT;
        rd_addr_d = wd1_q + wd2_q;
      end
      P_RT: begin
        state_d    = P_OUT;
        ks_d       = s_rd_data;
        ks_valid_d = 1'b1;
      end
      P_OUT: begin
        if (ks_valid_q && ks_ready) begin
          ks_valid_d = 1'b0;
          state_d    = P_RI;
          i_d        = i_q + 4'd1;
          rd_addr_d  = i_d;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (halt) begin
      state_d    = IDLE;
      i_d        = 4'd0;
      j_d        = 4'd0;
      ks_valid_d = 1'b0;
      wr_en_d    = 1'b0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= 4'd0;
      j_q        <= 4'd0;
      si_q       <= 4'd0;
      cnt_q      <= 3'd0;
      key_q      <= '0;
      rd_addr_q  <= 4'd0;
      wr_en_q    <= 1'b0;
      wa1_q      <= 4'd0;
      wd1_q      <= 4'd0;
      wa2_q      <= 4'd0;
      wd2_q      <= 4'd0;
      ks_q       <= 4'd0;
      ks_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wa1_q      <= wa1_d;
      wd1_q      <= wd1_d;
      wa2_q      <= wa2_d;
      wd2_q      <= wd2_d;
      ks_q       <= ks_d;
      ks_valid_q <= ks_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign s_rd_addr  = rd_addr_q;
  assign s_wr_en    = wr_en_q;
  assign s_wr_addr1 = wa1_q;
  assign s_wr_data1 = wd1_q;
  assign s_wr_addr2 = wa2_q;
  assign s_wr_data2 = wd2_q;
  assign ks         = ks_q;
  assign ks_valid   = ks_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rc4_ksa_prga_ctrl.sv
// Testbench for rc4_ksa_prga_ctrl: behavioural S-array plus scoreboard of
// expected keystream nibbles, with a monitor that checks accepted nibbles.
module tb_rc4_ksa_prga_ctrl;
  localparam int KEYLEN = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                halt = 1'b0;
  logic                ks_ready = 1'b0;
  logic [4*KEYLEN-1:0] key = '0;
  logic [3:0]          s_rd_addr, s_wr_addr1, s_wr_data1, s_wr_addr2, s_wr_data2, ks;
  logic [3:0]          s_rd_data = 4'd0;
  logic                s_wr_en, ks_valid, busy;

  rc4_ksa_prga_ctrl #(.KEYLEN(KEYLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .key(key),
    .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data), .s_wr_en(s_wr_en),
    .s_wr_addr1(s_wr_addr1), .s_wr_data1(s_wr_data1),
    .s_wr_addr2(s_wr_addr2), .s_wr_data2(s_wr_data2),
    .ks(ks), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural S-array: writes or reads on the falling edge. Preloaded with
  // values that differ from the identity so INIT has to do real work.
  logic [3:0] mem [16] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                           4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [3:0] snap [16];
  int wr_n = 0;
  int wr_base = 0;
  int wr_cyc [512];

  always @(negedge clk) begin
    if (s_wr_en) begin
      mem[s_wr_addr1] = s_wr_data1;
      mem[s_wr_addr2] = s_wr_data2;
      if (wr_n < 512) wr_cyc[wr_n] = cyc;
      wr_n = wr_n + 1;
      if (wr_n - wr_base == 24) snap = mem;   // 8 INIT + 16 KSA writes
    end else begin
      s_rd_data = mem[s_rd_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  int pops = 0;
  int pop_cyc [16];
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ks_valid && ks_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ks_unexpected: got %0d, required no output", ks);
        end else begin
          e = exp_q.pop_front();
          $display("ks nibble %0d accepted at cycle %0d (expected %0d)", ks, cyc, e);
          chk("ks", 32'(ks), e);
        end
        if (pops < 16) pop_cyc[pops] = cyc;
        pops++;
      end
    end
  endtask

  logic [3:0] ksa_exp [16] = '{4'd0, 4'd6, 4'd3, 4'd14, 4'd9, 4'd2, 4'd1, 4'd8,
                               4'd15, 4'd5, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd10};

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state
    ks_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ks_valid", 32'(ks_valid), 0);
    chk("rst_wr_en", 32'(s_wr_en), 0);
    chk("rst_rd_addr", 32'(s_rd_addr), 0);
    chk("rst_ks", 32'(ks), 0);
    rst = 1'b0;
    tick();

    // Run A: full sequence with ks_ready high
    wr_base = wr_n;
    exp_q.push_back(8); exp_q.push_back(15); exp_q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_rise", 32'(busy), 1);
    for (int c = 0; c < 8; c++) begin
      chk("init_write", 32'({s_wr_en, s_wr_addr1, s_wr_data1, s_wr_addr2, s_wr_data2}),
          (32'd1 << 16) | (32'(2*c) << 12) | (32'(2*c) << 8) | (32'(2*c+1) << 4) | 32'(2*c+1));
      tick();
    end
    n = 0;
    while (!ks_valid && n < 200) begin tick(); n++; end
    chk("first_ks_latency", 32'(cyc - start_cyc), 60);
    chk("ksa_cycles", 32'(wr_cyc[wr_base+23] - wr_cyc[wr_base+7]), 48);
    for (int k = 0; k < 16; k++) chk("ksa_array", 32'(snap[k]), 32'(ksa_exp[k]));
    n = 0;
    while (pops < 3 && n < 100) begin tick(); n++; end
    ks_ready = 1'b0;
    chk("runA_pops", 32'(pops), 3);
    chk("ks_spacing1", 32'(pop_cyc[1] - pop_cyc[0]), 5);
    chk("ks_spacing2", 32'(pop_cyc[2] - pop_cyc[1]), 5);
    chk("prga_S1", 32'(mem[1]), 1);
    chk("prga_S2", 32'(mem[2]), 5);
    chk("prga_S3", 32'(mem[3]), 8);
    chk("prga_S6", 32'(mem[6]), 6);
    chk("prga_S7", 32'(mem[7]), 14);
    chk("prga_S9", 32'(mem[9]), 3);

    // Abort during PRGA
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_busy", 32'(busy), 0);
    chk("halt_ks_valid", 32'(ks_valid), 0);
    chk("halt_wr_en", 32'(s_wr_en), 0);
    tick();

    // Run B: restart, a start pulse while busy, backpressure on first nibble
    wr_base = wr_n;
    exp_q.push_back(8); exp_q.push_back(15); exp_q.push_back(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    n = 0;
    while (!ks_valid && n < 200) begin
      if (n == 20) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    chk("restart_latency", 32'(cyc - start_cyc), 60);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", 32'({ks_valid, s_wr_en, ks}), 32'({1'b1, 1'b0, 4'd8}));
      tick();
    end
    ks_ready = 1'b1;
    n = 0;
    while (pops < 6 && n < 100) begin tick(); n++; end
    ks_ready = 1'b0;
    chk("runB_pops", 32'(pops), 6);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    // Run C: asynchronous reset in the middle of KSA
    halt = 1'b1;
    tick();
    halt = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    chk("pre_reset_wr_en", 32'(s_wr_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ks_valid", 32'(ks_valid), 0);
    chk("async_rst_wr_en", 32'(s_wr_en), 0);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_idle_wr_en", 32'(s_wr_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
